chi_revaluate_engine: RTL and testbench

Parametrised chi-step revaluation engine for the 3-D matrix encoder state. It snapshots a flattened NUM_ROW × NUM_COLUMN × NUM_PAGE bit state and computes every cell as a ⊕ (¬b ∧ c) along the row axis, LANES pages per cycle. Results are written into an internal result register, and completion is signalled with a start/busy/done handshake. It sits between the permutation stage and the output memory. It generalises the fixed 5×5×64, one-cell-per-cycle revaluate datapath with configurable geometry, multi-lane throughput, input snapshotting and optional round-constant injection.

---
 rtl/chi_revaluate_engine_pkg.sv | 32 +++
 rtl/chi_revaluate_engine_if.sv | 26 ++
 rtl/chi_revaluate_engine_index_counter.sv | 23 ++
 rtl/chi_revaluate_engine.sv | 142 ++++++++++++++
 tb/tb_chi_revaluate_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/chi_revaluate_engine_pkg.sv
// Shared definitions for the chi revaluation engine: default geometry,
// cell-index helpers and the FSM state type.
// Optional feature macro used by the engine: REVALUATE_IOTA_EN.
package revaluate_pkg;

   localparam int DEF_NUM_ROW    = 5;
   localparam int DEF_NUM_COLUMN = 5;
   localparam int DEF_NUM_PAGE   = 64;
   localparam int DEF_LANES      = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int num_cells(input int nr, input int nc, input int np);
      return nr * nc * np;
   endfunction

   // Flattened position of cell (i, j, k) in the state vector.
   function automatic int cell_index(input int i, input int j, input int k,
                                     input int nr, input int nc);
      return k * nr * nc + j * nr + i;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/chi_revaluate_engine_if.sv
// Request/result bundle between the permutation stage and the chi engine.
// master drives start/data_in (and rc with REVALUATE_IOTA_EN), slave returns busy/done/data_out.
// rc is present only when REVALUATE_IOTA_EN is defined.
interface chi_revaluate_engine_if
   import revaluate_pkg::*;
#(
   parameter int NUM_CELLS = num_cells(DEF_NUM_ROW, DEF_NUM_COLUMN, DEF_NUM_PAGE),
   parameter int NUM_PAGE  = DEF_NUM_PAGE
);
   logic                 start;
   logic [NUM_CELLS-1:0] data_in;
`ifdef REVALUATE_IOTA_EN
   logic [NUM_PAGE-1:0]  rc;
`endif
   logic                 busy;
   logic                 done;
   logic [NUM_CELLS-1:0] data_out;

`ifdef REVALUATE_IOTA_EN
   modport master (output start, data_in, rc, input busy, done, data_out);
   modport slave  (input start, data_in, rc, output busy, done, data_out);
`else
   modport master (output start, data_in, input busy, done, data_out);
   modport slave  (input start, data_in, output busy, done, data_out);
`endif
endinterface

// File: rtl/chi_revaluate_engine_index_counter.sv
// Wrap-around index counter; chained through overflow to build i -> j -> kb.
// Latency: out updates on the edge after en; overflow is combinational (en and out == max).
// No backpressure: counts whenever en is high, clr has priority.
module revaluate_index_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max,
   output logic         overflow,
   output logic [W-1:0] out
);
   assign overflow = en && (out == max);

   // count up, wrapping to zero after max
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          out <= '0;
      else if (clr)      out <= '0;
      else if (en)       out <= overflow ? '0 : out + 1'b1;
   end
endmodule

// File: rtl/chi_revaluate_engine.sv
// Chi step a ^ (~b & c) along the row axis over a snapshotted 3-D state, LANES pages per cycle.
// Latency: busy for N = cells/LANES cycles after start, done pulse in cycle N+1; one run per N+2 cycles.
// No backpressure: start is only accepted in IDLE; optional iota via REVALUATE_IOTA_EN.
module chi_revaluate_engine
   import revaluate_pkg::*;
#(
   parameter int NUM_ROW    = DEF_NUM_ROW,
   parameter int NUM_COLUMN = DEF_NUM_COLUMN,
   parameter int NUM_PAGE   = DEF_NUM_PAGE,
   parameter int LANES      = DEF_LANES
) (
   input  logic clk,
   input  logic rst,
   chi_revaluate_engine_if.slave bus
);
   localparam int NUM_CELLS = num_cells(NUM_ROW, NUM_COLUMN, NUM_PAGE);
   localparam int GROUPS    = NUM_PAGE / LANES;
   localparam int IW        = cnt_width(NUM_ROW);
   localparam int CW        = cnt_width(NUM_COLUMN);
   localparam int KW        = cnt_width(GROUPS);
   localparam int XW        = cnt_width(NUM_CELLS);
   localparam logic [IW:0] ROW_LIM = (IW+1)'(NUM_ROW);
   localparam logic [IW:0] ONE     = (IW+1)'(1);
   localparam logic [IW:0] TWO     = (IW+1)'(2);

   state_t state, state_nxt;
   logic   accept, run, last;
   logic   busy, done;

   logic [NUM_CELLS-1:0] snap;
   logic [NUM_CELLS-1:0] result;
`ifdef REVALUATE_IOTA_EN
   localparam int PW = cnt_width(NUM_PAGE);
   logic [NUM_PAGE-1:0] rc_snap;
   logic [PW-1:0]       kidx [LANES];
`endif

   logic [IW-1:0] i_cnt;
   logic [CW-1:0] j_cnt;
   logic [KW-1:0] kb_cnt;
   logic          i_ovf, j_ovf, kb_ovf;
   logic [IW:0]   i_p1, i_p2;

   logic [XW-1:0] idx0 [LANES];
   logic [XW-1:0] idx1 [LANES];
   logic [XW-1:0] idx2 [LANES];
   logic          bit_res [LANES];

   assign accept = (state == IDLE) && bus.start;
   assign run    = (state == RUN);
   assign last   = kb_ovf;

   revaluate_index_counter #(.W(IW)) u_cnt_i (
      .clk(clk), .rst(rst), .clr(accept), .en(run),
      .max(IW'(NUM_ROW - 1)), .overflow(i_ovf), .out(i_cnt));
   revaluate_index_counter #(.W(CW)) u_cnt_j (
      .clk(clk), .rst(rst), .clr(accept), .en(i_ovf),
      .max(CW'(NUM_COLUMN - 1)), .overflow(j_ovf), .out(j_cnt));
   revaluate_index_counter #(.W(KW)) u_cnt_kb (
      .clk(clk), .rst(rst), .clr(accept), .en(j_ovf),
      .max(KW'(GROUPS - 1)), .overflow(kb_ovf), .out(kb_cnt));

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // next-state: IDLE -> RUN on start, RUN -> DONE after the last group, DONE -> IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // handshake outputs decoded from state only
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.data_out = result;

   // row neighbours (i+1, i+2) mod NUM_ROW by a single compare-and-subtract
   always_comb begin
      i_p1 = {1'b0, i_cnt} + ONE;
      if (i_p1 >= ROW_LIM) i_p1 = i_p1 - ROW_LIM;
      i_p2 = {1'b0, i_cnt} + TWO;
      if (i_p2 >= ROW_LIM) i_p2 = i_p2 - ROW_LIM;
   end

   // per-lane addressing and chi result, reading the snapshot only
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         int k;
         k = int'(kb_cnt) * LANES + l;
         idx0[l] = XW'(cell_index(int'(i_cnt), int'(j_cnt), k, NUM_ROW, NUM_COLUMN));
         idx1[l] = XW'(cell_index(int'(i_p1[IW-1:0]), int'(j_cnt), k, NUM_ROW, NUM_COLUMN));
         idx2[l] = XW'(cell_index(int'(i_p2[IW-1:0]), int'(j_cnt), k, NUM_ROW, NUM_COLUMN));
         bit_res[l] = snap[idx0[l]] ^ (~snap[idx1[l]] & snap[idx2[l]]);
`ifdef REVALUATE_IOTA_EN
         kidx[l] = PW'(k);
         if (i_cnt == '0 && j_cnt == '0) bit_res[l] = bit_res[l] ^ rc_snap[kidx[l]];
`endif
      end
   end

   // capture the request so data_in may change once start has been taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap <= '0;
`ifdef REVALUATE_IOTA_EN
         rc_snap <= '0;
`endif
      end else if (accept) begin
         snap <= bus.data_in;
`ifdef REVALUATE_IOTA_EN
         rc_snap <= bus.rc;
`endif
      end
   end

   // progressive write of the current group into the result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
      end else if (run) begin
         for (int l = 0; l < LANES; l++) result[idx0[l]] <= bit_res[l];
      end
   end
endmodule

// File: tb/tb_chi_revaluate_engine.sv
// Bench for chi_revaluate_engine: LANES=1 and LANES=4 instances on shared clock/reset.
// Table of vectors plus sequences for mid-run start, data change, reset abort and iota.
// Expected results are queued at start and compared when done pulses.
module tb_chi_revaluate_engine;
   localparam int NC = 1600;
   localparam int NR = 5;
   localparam int NCOL = 5;
   localparam int NP = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   chi_revaluate_engine_if #(.NUM_CELLS(NC), .NUM_PAGE(NP)) if1 ();
   chi_revaluate_engine_if #(.NUM_CELLS(NC), .NUM_PAGE(NP)) if4 ();

   chi_revaluate_engine #(.NUM_ROW(NR), .NUM_COLUMN(NCOL), .NUM_PAGE(NP), .LANES(1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1));
   chi_revaluate_engine #(.NUM_ROW(NR), .NUM_COLUMN(NCOL), .NUM_PAGE(NP), .LANES(4)) dut4 (
      .clk(clk), .rst(rst), .bus(if4));

   int n_cmp = 0;
   int n_bad = 0;
   bit cur = 1'b0;
`ifdef REVALUATE_IOTA_EN
   logic [NP-1:0] rc_v = '0;
`endif

   wire          busy_m = cur ? if4.busy : if1.busy;
   wire          done_m = cur ? if4.done : if1.done;
   wire [NC-1:0] dout_m = cur ? if4.data_out : if1.data_out;

   logic [NC-1:0] sb_q [$];

   typedef struct {
      logic [NC-1:0] din;
      logic [NC-1:0] exp;
      bit            l4;
      string         name;
   } vec_t;
   vec_t tbl [7];

   function automatic logic [NC-1:0] chi_ref(input logic [NC-1:0] s);
      logic [NC-1:0] r;
      r = '0;
      for (int k = 0; k < NP; k++)
         for (int j = 0; j < NCOL; j++)
            for (int i = 0; i < NR; i++) begin
               int b;
               b = k * NR * NCOL + j * NR;
               r[b + i] = s[b + i] ^ (~s[b + (i + 1) % NR] & s[b + (i + 2) % NR]);
`ifdef REVALUATE_IOTA_EN
               if (i == 0 && j == 0) r[b] = r[b] ^ rc_v[k];
`endif
            end
      return r;
   endfunction

   function automatic logic [NC-1:0] rand_state();
      logic [NC-1:0] r;
      for (int w = 0; w < NC / 32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   task automatic chk_vec(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] req);
      int ndiff;
      int first;
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         ndiff = 0;
         first = -1;
         for (int b = 0; b < NC; b++)
            if (act[b] !== req[b]) begin
               ndiff++;
               if (first < 0) first = b;
            end
         $display("FAIL %s: data_out differs in %0d bits, first bit %0d got %b want %b",
                  nm, ndiff, first, act[first], req[first]);
      end
   endtask

   task automatic set_start(input bit v);
      if1.start = v & ~cur;
      if4.start = v & cur;
   endtask

   task automatic drive_data(input logic [NC-1:0] d);
      if1.data_in = d;
      if4.data_in = d;
`ifdef REVALUATE_IOTA_EN
      if1.rc = rc_v;
      if4.rc = rc_v;
`endif
   endtask

   // One run: start at the negedge before edge 0, then sample at each negedge (cycle c).
   task automatic do_run(input bit l4, input logic [NC-1:0] din, input logic [NC-1:0] exp,
                         input string nm, input bit disturb);
      int n, c, busy_cnt;
      bit seen, overlap;
      logic [NC-1:0] e;
      n = l4 ? NC / 4 : NC;
      @(negedge clk);
      cur = l4;
      drive_data(din);
      set_start(1'b1);
      sb_q.push_back(exp);
      @(negedge clk);
      set_start(1'b0);
      c = 1; busy_cnt = 0; seen = 1'b0; overlap = 1'b0;
      while (!seen && c <= n + 20) begin
         if (busy_m && done_m) overlap = 1'b1;
         if (busy_m) busy_cnt++;
         if (done_m) seen = 1'b1;
         else begin
            if (disturb && c == 10) begin
               set_start(1'b1);
               drive_data(~din);
            end
            if (disturb && c == 11) set_start(1'b0);
            c++;
            @(negedge clk);
         end
      end
      e = sb_q.pop_front();
      chk({nm, " done_seen"}, int'(seen), 1);
      chk({nm, " done_cycle"}, c, n + 1);
      chk({nm, " busy_cycles"}, busy_cnt, n);
      chk({nm, " busy_done_overlap"}, int'(overlap), 0);
      chk_vec({nm, " data_out"}, dout_m, e);
      @(negedge clk);
      chk({nm, " done_one_cycle"}, int'(done_m), 0);
      chk({nm, " idle_after_done"}, int'(busy_m), 0);
   endtask

   initial begin
      logic [NC-1:0] v, r;
      int c;

      set_start(1'b0);
      drive_data('0);
      cur = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset busy1", int'(if1.busy), 0);
      chk("reset done1", int'(if1.done), 0);
      chk_vec("reset data_out1", if1.data_out, '0);
      chk("reset busy4", int'(if4.busy), 0);
      chk_vec("reset data_out4", if4.data_out, '0);
      rst = 1'b1;

      // vector table
      tbl[0].din = '0; tbl[0].exp = '0; tbl[0].l4 = 1'b0; tbl[0].name = "zeros";
      v = '0; v[2] = 1'b1;
      r = '0; r[0] = 1'b1; r[2] = 1'b1;
      tbl[1].din = v; tbl[1].exp = r; tbl[1].l4 = 1'b0; tbl[1].name = "bit2";
      tbl[2].din = '1; tbl[2].exp = '1; tbl[2].l4 = 1'b0; tbl[2].name = "ones_l1";
      tbl[3].din = '1; tbl[3].exp = '1; tbl[3].l4 = 1'b1; tbl[3].name = "ones_l4";
      v = '0; v[1595] = 1'b1;
      r = '0; r[1595] = 1'b1; r[1598] = 1'b1;
      tbl[4].din = v; tbl[4].exp = r; tbl[4].l4 = 1'b1; tbl[4].name = "last_col_page";
      v = rand_state();
      tbl[5].din = v; tbl[5].exp = chi_ref(v); tbl[5].l4 = 1'b0; tbl[5].name = "rand_l1";
      tbl[6].din = v; tbl[6].exp = chi_ref(v); tbl[6].l4 = 1'b1; tbl[6].name = "rand_l4";

      for (int t = 0; t < 7; t++)
         do_run(tbl[t].l4, tbl[t].din, tbl[t].exp, tbl[t].name, 1'b0);

      // start pulsed mid-run and data_in changed after the start cycle
      v = rand_state();
      do_run(1'b0, v, chi_ref(v), "disturb_l1", 1'b1);
      v = rand_state();
      do_run(1'b1, v, chi_ref(v), "disturb_l4", 1'b1);

      // reset at cycle 500 of a run aborts it without a done pulse
      @(negedge clk);
      cur = 1'b0;
      drive_data('1);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      c = 1;
      while (c < 500) begin
         c++;
         @(negedge clk);
      end
      chk("pre_abort busy", int'(if1.busy), 1);
      rst = 1'b0;
      #1;
      chk("abort busy", int'(if1.busy), 0);
      chk("abort done", int'(if1.done), 0);
      chk_vec("abort data_out", if1.data_out, '0);
      @(negedge clk);
      rst = 1'b1;
      c = 0;
      for (int w = 0; w < 5; w++) begin
         @(negedge clk);
         if (if1.busy || if1.done) c++;
      end
      chk("abort stays idle", c, 0);
      v = rand_state();
      do_run(1'b0, v, chi_ref(v), "after_abort", 1'b0);

`ifdef REVALUATE_IOTA_EN
      rc_v = '0; rc_v[0] = 1'b1;
      r = '0; r[0] = 1'b1;
      do_run(1'b0, '0, r, "iota_rc1", 1'b0);
      rc_v = {$urandom, $urandom};
      v = rand_state();
      do_run(1'b1, v, chi_ref(v), "iota_rand_l4", 1'b0);
`endif

      chk("scoreboard empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
